// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access / write-back stage.
// Default widths and the memory handshake FSM encoding.
package mem_wb_stage_pkg;

    localparam int DW_DEF       = 32;
    localparam int RW_DEF       = 5;
    localparam int MAX_WAIT_DEF = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load-enable and bubble insertion.
// wdo has its own enable so it holds across non-load instructions.
module mem_wb_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          bubble_i,
    input  logic          wdo_load_i,
    input  logic          wreg_i,
    input  logic          m2reg_i,
    input  logic [RW-1:0] rn_i,
    input  logic [DW-1:0] alu_i,
    input  logic [DW-1:0] wdo_i,
    output logic          wvalid_o,
    output logic          wwreg_o,
    output logic          wm2reg_o,
    output logic [RW-1:0] wrn_o,
    output logic [DW-1:0] walu_o,
    output logic [DW-1:0] wdo_o
);

    logic          valid_q, valid_d;
    logic          wreg_q, wreg_d;
    logic          m2reg_q, m2reg_d;
    logic [RW-1:0] rn_q, rn_d;
    logic [DW-1:0] alu_q, alu_d;
    logic [DW-1:0] wdo_q, wdo_d;

    always_comb begin
        valid_d = valid_q;
        wreg_d  = wreg_q;
        m2reg_d = m2reg_q;
        rn_d    = rn_q;
        alu_d   = alu_q;
        wdo_d   = wdo_q;
        if (bubble_i) begin
            valid_d = 1'b0;
            wreg_d  = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            wreg_d  = wreg_i;
            m2reg_d = m2reg_i;
            rn_d    = rn_i;
            alu_d   = alu_i;
            if (wdo_load_i) begin
                wdo_d = wdo_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            rn_q    <= '0;
            alu_q   <= '0;
            wdo_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            rn_q    <= rn_d;
            alu_q   <= alu_d;
            wdo_q   <= wdo_d;
        end
    end

    assign wvalid_o = valid_q;
    assign wwreg_o  = wreg_q;
    assign wm2reg_o = m2reg_q;
    assign wrn_o    = rn_q;
    assign walu_o   = alu_q;
    assign wdo_o    = wdo_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access controller (req/ack with timeout) feeding the
// MEM/WB pipeline register; stalls upstream during wait states.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int RW       = RW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mvalid,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [RW-1:0] mrn,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mb,
    output logic          dm_req,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_ack,
    output logic          stall,
    output logic          wvalid,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [RW-1:0] wrn,
    output logic [DW-1:0] walu,
    output logic [DW-1:0] wdo,
    output logic          dm_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [CW-1:0] elapsed;
    logic          access, in_wait, complete, abort;
    logic          is_load, wb_load;

    assign access  = mvalid & (mm2reg | mwmem);
    assign in_wait = (state_q == ST_WAIT);
    assign is_load = mm2reg & ~mwmem;

    assign dm_req   = ~rst & (in_wait | access);
    assign dm_we    = mwmem;
    assign dm_addr  = malu;
    assign dm_wdata = mb;

    // wait states already spent before this cycle's ack sample
    assign elapsed  = in_wait ? cnt_q + CW'(1) : '0;
    assign complete = dm_req & dm_ack;
    assign abort    = dm_req & ~dm_ack & (elapsed == CW'(MAX_WAIT - 1));
    assign stall    = dm_req & ~dm_ack & ~abort;
    assign wb_load  = mvalid & ~stall;
    assign err_d    = err_q | abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (stall) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (complete | abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign dm_err = err_q;

    mem_wb_reg #(
        .DW(DW),
        .RW(RW)
    ) u_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (wb_load),
        .bubble_i  (~wb_load),
        .wdo_load_i((complete & is_load) | abort),
        .wreg_i    (mwreg & ~mwmem & ~abort),
        .m2reg_i   (mm2reg),
        .rn_i      (mrn),
        .alu_i     (malu),
        .wdo_i     (abort ? '0 : dm_rdata),
        .wvalid_o  (wvalid),
        .wwreg_o   (wwreg),
        .wm2reg_o  (wm2reg),
        .wrn_o     (wrn),
        .walu_o    (walu),
        .wdo_o     (wdo)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a transaction-level driver
// predicts each cycle's response; a monitor pops and compares.
module tb_mem_wb_stage;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mvalid = 1'b0, mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
    logic [4:0]  mrn = '0;
    logic [31:0] malu = '0, mb = '0, dm_rdata = '0;
    logic        dm_ack = 1'b0;
    logic        dm_req, dm_we, stall, wvalid, wwreg, wm2reg, dm_err;
    logic [31:0] dm_addr, dm_wdata, walu, wdo;
    logic [4:0]  wrn;

    always #5 clk = ~clk;

    mem_wb_stage #(.DW(32), .RW(5), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .mvalid(mvalid), .mwreg(mwreg),
        .mm2reg(mm2reg), .mwmem(mwmem), .mrn(mrn), .malu(malu),
        .mb(mb), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall(stall), .wvalid(wvalid), .wwreg(wwreg), .wm2reg(wm2reg),
        .wrn(wrn), .walu(walu), .wdo(wdo), .dm_err(dm_err)
    );

    typedef struct {
        bit          rst;
        bit          req;
        bit          stall;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          bub;
        bit          wreg;
        bit          m2reg;
        logic [4:0]  rn;
        logic [31:0] alu;
        logic [31:0] dout;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wdo_m = '0;
    bit          err_m = 1'b0;

    task automatic chk(string n, logic [31:0] a, logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(bit v, bit wr, bit ld, bit st, logic [4:0] rn,
                         logic [31:0] alu, logic [31:0] b);
        rst = 1'b0; mvalid = v; mwreg = wr; mm2reg = ld; mwmem = st;
        mrn = rn; malu = alu; mb = b;
    endtask

    task automatic rst_cycle();
        exp_t e;
        step();
        rst = 1'b1;
        dm_ack = 1'b0;
        e = '{default: 0};
        e.rst = 1;
        exp_q.push_back(e);
        wdo_m = '0;
        err_m = 1'b0;
    endtask

    task automatic issue(bit v, bit wr, bit ld, bit st, logic [4:0] rn,
                         logic [31:0] alu, logic [31:0] b, int nw,
                         logic [31:0] rd);
        exp_t e;
        bit   acc;
        bit   tmo;
        int   stl;
        acc = v & (ld | st);
        if (!acc) begin
            step();
            drive(v, wr, ld, st, rn, alu, b);
            dm_ack = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
            e = '{default: 0};
            e.bub = !v; e.wreg = wr; e.m2reg = ld; e.rn = rn; e.alu = alu;
            e.dout = wdo_m; e.err = err_m;
            exp_q.push_back(e);
            return;
        end
        tmo = (nw >= MAXW);
        stl = tmo ? MAXW - 1 : nw;
        for (int c = 0; c <= stl; c++) begin
            step();
            drive(v, wr, ld, st, rn, alu, b);
            dm_ack = (!tmo && c == nw);
            dm_rdata = dm_ack ? rd : $urandom;
            e = '{default: 0};
            e.req = 1; e.we = st; e.addr = alu; e.wdata = b;
            e.stall = (c < stl);
            if (c < stl) begin
                e.bub = 1;
            end else begin
                e.wreg = !tmo && wr && !st;
                e.m2reg = ld; e.rn = rn; e.alu = alu;
                if (tmo) begin
                    wdo_m = '0;
                    err_m = 1'b1;
                end else if (ld && !st) begin
                    wdo_m = rd;
                end
                e.dout = wdo_m;
            end
            e.err = err_m;
            exp_q.push_back(e);
        end
    endtask

    task automatic rst_mid_wait();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            step();
            drive(1, 1, 1, 0, 5'd3, 32'h300, 32'h0);
            dm_ack = 1'b0;
            e = '{default: 0};
            e.req = 1; e.stall = 1; e.addr = 32'h300; e.bub = 1;
            e.err = err_m;
            exp_q.push_back(e);
        end
        rst_cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dm_req", dm_req, e.req);
                chk("stall", stall, e.stall);
                if (e.req) begin
                    chk("dm_we", dm_we, e.we);
                    chk("dm_addr", dm_addr, e.addr);
                    chk("dm_wdata", dm_wdata, e.wdata);
                end
                @(posedge clk);
                #1;
                if (e.rst) begin
                    chk("rst_wvalid", wvalid, 0);
                    chk("rst_wwreg", wwreg, 0);
                    chk("rst_wm2reg", wm2reg, 0);
                    chk("rst_wrn", wrn, 0);
                    chk("rst_walu", walu, 0);
                    chk("rst_wdo", wdo, 0);
                    chk("rst_dm_err", dm_err, 0);
                end else begin
                    chk("wvalid", wvalid, !e.bub);
                    chk("dm_err", dm_err, e.err);
                    if (e.bub) begin
                        chk("bubble_wwreg", wwreg, 0);
                    end else begin
                        chk("wwreg", wwreg, e.wreg);
                        chk("wm2reg", wm2reg, e.m2reg);
                        chk("wrn", wrn, e.rn);
                        chk("walu", walu, e.alu);
                        chk("wdo", wdo, e.dout);
                    end
                end
            end
        end
    end

    initial begin : driver
        int k;
        rst_cycle();
        rst_cycle();
        issue(1, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 0, 32'h0);
        issue(1, 1, 1, 0, 5'd7, 32'h40, 32'h0, 0, 32'hDEADBEEF);
        issue(1, 1, 1, 0, 5'd8, 32'h80, 32'h0, 3, 32'hCAFEF00D);
        issue(1, 1, 0, 1, 5'd0, 32'h100, 32'hA5A5A5A5, 1, 32'h0);
        issue(0, 1, 1, 0, 5'd2, 32'h44, 32'h0, 0, 32'h0);
        issue(1, 1, 1, 0, 5'd9, 32'h200, 32'h0, 10, 32'h0);
        issue(1, 1, 0, 0, 5'd10, 32'h55, 32'h0, 0, 32'h0);
        issue(1, 1, 1, 1, 5'd11, 32'h204, 32'h1111, 2, 32'h0BAD0BAD);
        rst_mid_wait();
        issue(1, 1, 1, 0, 5'd12, 32'h60, 32'h0, 0, 32'h12345678);
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 5);
            case (k)
                0: issue(1, 1'($urandom_range(0, 1)), 0, 0, 5'($urandom),
                         $urandom, $urandom, 0, 0);
                1, 2: issue(1, 1'($urandom_range(0, 1)), 1, 0, 5'($urandom),
                            $urandom, $urandom, $urandom_range(0, 5), $urandom);
                3: issue(1, 1'($urandom_range(0, 1)), 0, 1, 5'($urandom),
                         $urandom, $urandom, $urandom_range(0, 5), 0);
                4: issue(1, 1, 1, 1, 5'($urandom), $urandom, $urandom,
                         $urandom_range(0, 5), $urandom);
                default: issue(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               0, 5'($urandom), $urandom, $urandom, 0, 0);
            endcase
        end
        issue(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        issue(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
